// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer.
//   Circular buffer of DEPTH entries (busy, done, rt, value) with
//   wrap-bit head/tail pointers.
// Ports:
//   clk, reset            - rising-edge clock, async active-high reset
//   disp_valid/disp_rt    - per-lane dispatch request and target register
//   disp_ready            - all DISP_W lanes can be accepted this cycle
//   disp_idx              - tag each lane would receive (combinational)
//   cdb_valid/idx/data    - result writeback ports
//   flush_valid/flush_idx - mispredict: squash every entry younger than flush_idx
//   commit_we/rt/data/tag - in-order multi-lane retirement to the register file
//   head, count, full, empty - occupancy status
module rob_param #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned DISP_W   = 4,
  parameter int unsigned CDB_W    = 4,
  parameter int unsigned COMMIT_W = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned REG_W    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DISP_W-1:0]            disp_valid,
  input  logic [DISP_W*REG_W-1:0]      disp_rt,
  output logic                         disp_ready,
  output logic [DISP_W*IDX_W-1:0]      disp_idx,
  input  logic [CDB_W-1:0]             cdb_valid,
  input  logic [CDB_W*IDX_W-1:0]       cdb_idx,
  input  logic [CDB_W*DATA_W-1:0]      cdb_data,
  input  logic                         flush_valid,
  input  logic [IDX_W-1:0]             flush_idx,
  output logic [COMMIT_W-1:0]          commit_we,
  output logic [COMMIT_W*REG_W-1:0]    commit_rt,
  output logic [COMMIT_W*DATA_W-1:0]   commit_data,
  output logic [COMMIT_W*IDX_W-1:0]    commit_tag,
  output logic [IDX_W-1:0]             head,
  output logic [IDX_W:0]               count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = IDX_W + 1;

  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d;
  logic [REG_W-1:0]  rt_q  [DEPTH];
  logic [REG_W-1:0]  rt_d  [DEPTH];
  logic [DATA_W-1:0] val_q [DEPTH];
  logic [DATA_W-1:0] val_d [DEPTH];

  logic [PW-1:0]     occ;
  logic              flush_ok;
  logic [IDX_W-1:0]  flush_off;
  logic [PW-1:0]     disp_cnt;
  logic [PW-1:0]     n_commit;
  logic [DEPTH-1:0]  squash;
  logic              chain;
  logic [IDX_W-1:0]  cent;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  aidx;

  // Occupancy, flush acceptance and dispatch readiness use registered state
  // only, so a same-cycle commit never opens space for dispatch.
  always_comb begin
    occ        = tail_q - head_q;
    flush_ok   = flush_valid && busy_q[flush_idx];
    flush_off  = flush_idx - head_q[IDX_W-1:0];
    disp_ready = !flush_ok &&
                 (({1'b0, occ} + (PW+1)'(DISP_W)) <= (PW+1)'(DEPTH));
  end

  // Lane i takes tail + (number of valid lanes below it).
  always_comb begin
    disp_cnt = '0;
    disp_idx = '0;
    for (int unsigned i = 0; i < DISP_W; i++) begin
      disp_idx[i*IDX_W +: IDX_W] = tail_q[IDX_W-1:0] + disp_cnt[IDX_W-1:0];
      if (disp_valid[i]) disp_cnt = disp_cnt + PW'(1);
    end
  end

  // Younger than the flushed branch means a larger age offset from head.
  always_comb begin
    squash = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      squash[i] = flush_ok && busy_q[i] &&
                  ((IDX_W'(i) - head_q[IDX_W-1:0]) > flush_off);
    end
  end

  // In-order commit chain. During an accepted flush only entries up to and
  // including the branch may retire, keeping the rewound tail consistent.
  always_comb begin
    chain       = 1'b1;
    cent        = '0;
    n_commit    = '0;
    commit_we   = '0;
    commit_rt   = '0;
    commit_data = '0;
    commit_tag  = '0;
    for (int unsigned j = 0; j < COMMIT_W; j++) begin
      cent  = head_q[IDX_W-1:0] + IDX_W'(j);
      chain = chain && (PW'(j) < occ) && busy_q[cent] && done_q[cent] &&
              !(flush_ok && (IDX_W'(j) > flush_off));
      commit_we[j]                      = chain;
      commit_tag[j*IDX_W +: IDX_W]      = cent;
      commit_rt[j*REG_W +: REG_W]       = rt_q[cent];
      commit_data[j*DATA_W +: DATA_W]   = val_q[cent];
      if (chain) n_commit = n_commit + PW'(1);
    end
  end

  always_comb begin
    head_d = head_q + n_commit;
    tail_d = tail_q;
    busy_d = busy_q;
    done_d = done_q;
    rt_d   = rt_q;
    val_d  = val_q;
    widx   = '0;
    aidx   = '0;

    // Ascending port order: the highest-numbered port writing a tag wins.
    for (int unsigned p = 0; p < CDB_W; p++) begin
      widx = cdb_idx[p*IDX_W +: IDX_W];
      if (cdb_valid[p] && busy_q[widx] && !squash[widx]) begin
        val_d[widx]  = cdb_data[p*DATA_W +: DATA_W];
        done_d[widx] = 1'b1;
      end
    end

    for (int unsigned j = 0; j < COMMIT_W; j++) begin
      if (commit_we[j]) begin
        busy_d[commit_tag[j*IDX_W +: IDX_W]] = 1'b0;
        done_d[commit_tag[j*IDX_W +: IDX_W]] = 1'b0;
      end
    end

    busy_d = busy_d & ~squash;
    done_d = done_d & ~squash;

    if (flush_ok) begin
      tail_d = head_q + {1'b0, flush_off} + PW'(1);
    end else if (disp_ready) begin
      tail_d = tail_q + disp_cnt;
      for (int unsigned i = 0; i < DISP_W; i++) begin
        if (disp_valid[i]) begin
          aidx         = disp_idx[i*IDX_W +: IDX_W];
          busy_d[aidx] = 1'b1;
          done_d[aidx] = 1'b0;
          rt_d[aidx]   = disp_rt[i*REG_W +: REG_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      busy_q <= '0;
      done_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rt_q[i]  <= '0;
        val_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      busy_q <= busy_d;
      done_q <= done_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rt_q[i]  <= rt_d[i];
        val_q[i] <= val_d[i];
      end
    end
  end

  assign head  = head_q[IDX_W-1:0];
  assign count = occ;
  assign full  = (occ == PW'(DEPTH));
  assign empty = (occ == '0);

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed-vector bench for rob_param with default parameters.
module tb_rob_param;

  logic        clk;
  logic        reset;
  logic [3:0]  disp_valid;
  logic [15:0] disp_rt;
  logic        disp_ready;
  logic [15:0] disp_idx;
  logic [3:0]  cdb_valid;
  logic [15:0] cdb_idx;
  logic [63:0] cdb_data;
  logic        flush_valid;
  logic [3:0]  flush_idx;
  logic [3:0]  commit_we;
  logic [15:0] commit_rt;
  logic [63:0] commit_data;
  logic [15:0] commit_tag;
  logic [3:0]  head;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  int unsigned n_checks;
  int unsigned n_errors;

  rob_param #(
    .DEPTH(16), .IDX_W(4), .DISP_W(4), .CDB_W(4),
    .COMMIT_W(4), .DATA_W(16), .REG_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_rt(disp_rt),
    .disp_ready(disp_ready), .disp_idx(disp_idx),
    .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_data(cdb_data),
    .flush_valid(flush_valid), .flush_idx(flush_idx),
    .commit_we(commit_we), .commit_rt(commit_rt),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .head(head), .count(count), .full(full), .empty(empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_valid  = '0;
    disp_rt     = '0;
    cdb_valid   = '0;
    cdb_idx     = '0;
    cdb_data    = '0;
    flush_valid = 1'b0;
    flush_idx   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    idle_inputs();
    #1 reset = 1'b1;
    #2;
    // ---- 1: reset state and first 4-lane dispatch
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ready", 64'(disp_ready), 64'd1);
    check("rst_we", 64'(commit_we), 64'd0);
    check("rst_head", 64'(head), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    disp_valid = 4'b1111;
    disp_rt    = 16'h4321;
    #1;
    check("t1_idx", 64'(disp_idx), 64'h3210);
    check("t1_ready", 64'(disp_ready), 64'd1);
    tick();
    idle_inputs();
    #1;
    check("t1_count", 64'(count), 64'd4);
    check("t1_we", 64'(commit_we), 64'd0);
    check("t1_empty", 64'(empty), 64'd0);

    // ---- 2: out-of-order writeback, in-order commit, same-tag priority
    cdb_valid = 4'b0001;
    cdb_idx   = 16'h0002;
    cdb_data  = 64'h0000_0000_0000_BEEF;
    tick();
    check("t2_we_a", 64'(commit_we), 64'd0);
    cdb_valid = 4'b0111;
    cdb_idx   = 16'h0010;                        // p0->0, p1->1, p2->0
    cdb_data  = 64'h0000_0011_0022_7777;
    #1;
    check("t2_we_b", 64'(commit_we), 64'd0);
    tick();
    idle_inputs();
    #1;
    check("t2_we", 64'(commit_we), 64'b0111);
    check("t2_rt", 64'(commit_rt[11:0]), 64'h321);
    check("t2_data", 64'(commit_data[47:0]), 64'hBEEF_0022_0011);
    check("t2_tag", 64'(commit_tag[11:0]), 64'h210);
    tick();
    check("t2_head", 64'(head), 64'd3);
    check("t2_count", 64'(count), 64'd1);
    check("t2_we_c", 64'(commit_we), 64'd0);

    // ---- 3: fill to full, wrap of tail, full blocks held dispatch
    disp_rt    = 16'h5555;
    disp_valid = 4'b1111;
    #1;
    check("t3_idx1", 64'(disp_idx), 64'h7654);
    tick();
    check("t3_idx2", 64'(disp_idx), 64'hBA98);
    tick();
    disp_valid = 4'b0111;
    #1;
    check("t3_idx3", 64'(disp_idx), 64'hFEDC);
    tick();
    disp_valid = 4'b1111;
    #1;
    check("t3_count12", 64'(count), 64'd12);
    check("t3_ready12", 64'(disp_ready), 64'd1);
    check("t3_idx4", 64'(disp_idx), 64'h210F);
    tick();
    check("t3_full", 64'(full), 64'd1);
    check("t3_count16", 64'(count), 64'd16);
    check("t3_ready_full", 64'(disp_ready), 64'd0);
    tick();
    check("t3_hold_count", 64'(count), 64'd16);
    check("t3_hold_idx", 64'(disp_idx), 64'h6543);
    cdb_valid = 4'b0001;
    cdb_idx   = 16'h0003;
    cdb_data  = 64'h0000_0000_0000_1234;
    tick();
    cdb_valid = '0;
    #1;
    check("t3_we", 64'(commit_we), 64'b0001);
    check("t3_ctag", 64'(commit_tag[3:0]), 64'd3);
    check("t3_cdata", 64'(commit_data[15:0]), 64'h1234);
    check("t3_crt", 64'(commit_rt[3:0]), 64'd4);
    check("t3_ready_c", 64'(disp_ready), 64'd0);
    tick();
    check("t3_count15", 64'(count), 64'd15);
    check("t3_full15", 64'(full), 64'd0);
    check("t3_ready15", 64'(disp_ready), 64'd0);
    check("t3_head4", 64'(head), 64'd4);
    tick();
    check("t3_count15b", 64'(count), 64'd15);

    // ---- 4: sparse lanes, then single-lane traffic wrapping the tail
    do_reset();
    disp_valid = 4'b1010;
    disp_rt    = 16'h8070;
    #1;
    check("t4_idx", 64'(disp_idx), 64'h1100);
    tick();
    idle_inputs();
    #1;
    check("t4_count2", 64'(count), 64'd2);
    check("t4_tail", 64'(disp_idx[3:0]), 64'd2);
    cdb_valid = 4'b0011;
    cdb_idx   = 16'h0010;
    cdb_data  = 64'h0000_0000_0B0B_0A0A;
    tick();
    idle_inputs();
    #1;
    check("t4_we", 64'(commit_we), 64'b0011);
    check("t4_rt", 64'(commit_rt[7:0]), 64'h87);
    check("t4_data", 64'(commit_data[31:0]), 64'h0B0B_0A0A);
    tick();
    check("t4_empty", 64'(empty), 64'd1);
    check("t4_head", 64'(head), 64'd2);

    for (int k = 0; k < 20; k++) begin
      disp_valid = 4'b0001;
      disp_rt    = 16'(k % 16);
      cdb_valid  = (k > 0) ? 4'b0001 : 4'b0000;
      cdb_idx    = 16'((k + 1) % 16);
      cdb_data   = 64'(((k + 1) % 16) * 257);
      #1;
      check("t4_lp_idx", 64'(disp_idx[3:0]), 64'((2 + k) % 16));
      check("t4_lp_count", 64'(count), 64'((k < 2) ? k : 2));
      check("t4_lp_full", 64'(full), 64'd0);
      check("t4_lp_we", 64'(commit_we), 64'((k >= 2) ? 1 : 0));
      if (k >= 2) begin
        check("t4_lp_ctag", 64'(commit_tag[3:0]), 64'(k % 16));
        check("t4_lp_cdata", 64'(commit_data[15:0]), 64'((k % 16) * 257));
      end
      tick();
    end
    idle_inputs();
    #1;
    check("t4_end_count", 64'(count), 64'd2);

    // ---- 5: flush of younger entries
    do_reset();
    disp_valid = 4'b1111;
    disp_rt    = 16'h4321;
    tick();
    disp_valid = 4'b0001;
    cdb_valid  = 4'b1111;
    cdb_idx    = 16'h3210;
    cdb_data   = 64'h0004_0003_0002_0001;
    tick();
    disp_valid = '0;
    cdb_valid  = 4'b0001;
    cdb_idx    = 16'h0004;
    cdb_data   = 64'h0000_0000_0000_0005;
    #1;
    check("t5_we4", 64'(commit_we), 64'b1111);
    tick();
    cdb_valid  = '0;
    disp_valid = 4'b1111;
    #1;
    check("t5_we1", 64'(commit_we), 64'b0001);
    check("t5_idx58", 64'(disp_idx), 64'h8765);
    tick();
    disp_valid = 4'b0011;
    #1;
    check("t5_idx910", 64'(disp_idx), 64'hBBA9);
    tick();
    idle_inputs();
    #1;
    check("t5_count6", 64'(count), 64'd6);
    check("t5_head5", 64'(head), 64'd5);

    flush_valid = 1'b1;
    flush_idx   = 4'd7;
    cdb_valid   = 4'b0001;
    cdb_idx     = 16'h0009;
    cdb_data    = 64'h0000_0000_0000_AAAA;
    disp_valid  = 4'b1111;
    #1;
    check("t5_fl_ready", 64'(disp_ready), 64'd0);
    tick();
    idle_inputs();
    #1;
    check("t5_fl_count", 64'(count), 64'd3);
    check("t5_fl_tail", 64'(disp_idx), 64'h8888);
    flush_valid = 1'b1;
    flush_idx   = 4'd9;                          // squashed, so not busy
    #1;
    check("t5_ign_ready", 64'(disp_ready), 64'd1);
    tick();
    idle_inputs();
    #1;
    check("t5_ign_count", 64'(count), 64'd3);
    cdb_valid = 4'b1111;
    cdb_idx   = 16'h9765;
    cdb_data  = 64'hAAAA_0007_0006_0005;
    tick();
    idle_inputs();
    #1;
    check("t5_cm_we", 64'(commit_we), 64'b0111);
    check("t5_cm_data", 64'(commit_data[47:0]), 64'h0007_0006_0005);
    tick();
    check("t5_cm_empty", 64'(empty), 64'd1);
    check("t5_cm_head", 64'(head), 64'd8);

    // flush naming the entry that commits in the same cycle
    disp_valid = 4'b0011;
    tick();
    idle_inputs();
    cdb_valid = 4'b0001;
    cdb_idx   = 16'h0008;
    cdb_data  = 64'h0000_0000_0000_0888;
    tick();
    idle_inputs();
    flush_valid = 1'b1;
    flush_idx   = 4'd8;
    #1;
    check("t5_fc_we", 64'(commit_we), 64'b0001);
    check("t5_fc_cnt", 64'(count), 64'd2);
    tick();
    idle_inputs();
    #1;
    check("t5_fc_count", 64'(count), 64'd0);
    check("t5_fc_head", 64'(head), 64'd9);
    check("t5_fc_tail", 64'(disp_idx[3:0]), 64'd9);

    // ---- 6: asynchronous reset mid-burst
    do_reset();
    disp_valid = 4'b1111;
    disp_rt    = 16'h1111;
    tick();
    tick();
    disp_valid = '0;
    cdb_valid  = 4'b1111;
    cdb_idx    = 16'h4321;
    cdb_data   = 64'h0044_0033_0022_0011;
    tick();
    cdb_valid = 4'b0011;
    cdb_idx   = 16'h0065;
    tick();
    idle_inputs();
    #1;
    check("t6_count8", 64'(count), 64'd8);
    check("t6_we0", 64'(commit_we), 64'd0);
    #1 reset = 1'b1;
    #1;
    check("t6_ar_count", 64'(count), 64'd0);
    check("t6_ar_empty", 64'(empty), 64'd1);
    check("t6_ar_head", 64'(head), 64'd0);
    check("t6_ar_we", 64'(commit_we), 64'd0);
    check("t6_ar_ready", 64'(disp_ready), 64'd1);
    check("t6_ar_full", 64'(full), 64'd0);
    cdb_valid = 4'b0001;
    cdb_idx   = 16'h0000;
    tick();
    check("t6_hold_we", 64'(commit_we), 64'd0);
    check("t6_hold_count", 64'(count), 64'd0);
    idle_inputs();
    #2 reset = 1'b0;
    tick();
    check("t6_post_count", 64'(count), 64'd0);
    check("t6_post_we", 64'(commit_we), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
